// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundle of requester-side and uart_tx-side signals for
// uart_tx_arbiter.
//   req_valid  [NUM_REQ]   : requester i offers a byte
//   req_data   [8*NUM_REQ] : byte of requester i on bits [8i+7:8i]
//   req_last   [NUM_REQ]   : last byte of a message (message-lock builds only)
//   req_ready  [NUM_REQ]   : one-hot accept strobe
//   tx_start               : one-cycle start pulse to uart_tx
//   tx_data_in [8]         : byte presented to uart_tx
//   tx_busy                : busy flag returned by uart_tx
//   grant_id   [ID_W]      : index of the last accepted requester
//   active                 : arbiter FSM is not idle
// modport slave is the arbiter; modport master is the surrounding system
// (requesters plus uart_tx).
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data_in;
  logic                 tx_busy;
  logic [ID_W-1:0]      grant_id;
  logic                 active;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data_in, grant_id, active
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data_in, grant_id, active
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx between NUM_REQ
// byte-stream requesters. One byte is accepted per valid/ready handshake,
// handed to uart_tx with a one-cycle tx_start, and the arbiter then follows
// tx_busy until the frame is over before granting again.
// Ports:
//   clk  : block clock
//   rst  : asynchronous, active-high reset
//   bus  : uart_tx_arbiter_if.slave (requester handshake + uart_tx signals)
// Optional build macro UART_ARB_LOCK_EN: a byte accepted with req_last=0 locks
// the arbiter to its requester until a byte with req_last=1 is accepted.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic               wd_cnt;     // second cycle spent in WAIT_BUSY
  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [SEL_W-1:0]   win_sel;
  logic [ID_W-1:0]    win_id;
  logic               accept;

`ifdef UART_ARB_LOCK_EN
  logic            locked;
  logic [ID_W-1:0] lock_id;

  // While a message is open only its owner may be chosen, even if it is
  // momentarily not offering a byte.
  always_comb begin
    eligible = '0;
    if (locked) eligible[SEL_W'(lock_id)] = bus.req_valid[SEL_W'(lock_id)];
    else        eligible = bus.req_valid;
  end
`else
  logic [NUM_REQ-1:0] unused_req_last;
  assign unused_req_last = bus.req_last;
  assign eligible        = bus.req_valid;
`endif

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] sel_k;
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    found   = 1'b0;
    win_sel = '0;
    win_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel_k = SEL_W'(idx);
      if (!found && eligible[sel_k]) begin
        found   = 1'b1;
        win_sel = sel_k;
        win_id  = ID_W'(idx);
      end
    end
  end

  // rst is in the term because the state register alone already reads IDLE
  // while reset is held, which would otherwise let a ready through.
  assign accept = (state == IDLE) && !bus.tx_busy && found && !rst;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[win_sel] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy)  state_nxt = WAIT_DONE;
        else if (wd_cnt)  state_nxt = IDLE;   // uart_tx never answered
      end
      WAIT_DONE: if (!bus.tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign bus.tx_start = (state == START);
  assign bus.active   = (state != IDLE);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= ID_W'(NUM_REQ - 1);
      wd_cnt         <= 1'b0;
      bus.tx_data_in <= 8'h00;
      bus.grant_id   <= '0;
`ifdef UART_ARB_LOCK_EN
      locked         <= 1'b0;
      lock_id        <= '0;
`endif
    end else begin
      state  <= state_nxt;
      wd_cnt <= (state == WAIT_BUSY);
      if (accept) begin
        bus.tx_data_in <= bus.req_data[8*int'(win_sel) +: 8];
        bus.grant_id   <= win_id;
        rr_ptr         <= win_id;
`ifdef UART_ARB_LOCK_EN
        locked         <= ~bus.req_last[win_sel];
        lock_id        <= win_id;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with NUM_REQ=2.
// A small uart_tx stand-in raises tx_busy one cycle after tx_start and holds
// it for a few cycles; tx_busy can also be forced high or low.
module tb_uart_tx_arbiter;

  localparam int BUSY_LEN = 6;

  logic tb_clk = 1'b0;
  logic rst    = 1'b1;
  always #5 tb_clk = ~tb_clk;

  uart_tx_arbiter_if #(.NUM_REQ(2), .ID_W(1)) bus ();

  uart_tx_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
    .clk (tb_clk),
    .rst (rst),
    .bus (bus)
  );

  // stimulus variables (single writer: the main initial block)
  logic [1:0]  v_valid = '0;
  logic [15:0] v_data  = '0;
  logic [1:0]  v_last  = '0;
  int          mode    = 0;     // 0 model, 1 forced busy, 2 forced idle

  int  busy_cnt;
  logic model_busy;

  assign bus.req_valid = v_valid;
  assign bus.req_data  = v_data;
  assign bus.req_last  = v_last;
  assign model_busy    = (busy_cnt != 0);
  assign bus.tx_busy   = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : model_busy;

  always @(posedge tb_clk or posedge rst) begin
    if (rst)                busy_cnt <= 0;
    else if (bus.tx_start)  busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  typedef struct {
    int gid;
    int data;
  } ent_t;

  typedef struct {
    string      name;
    logic       rst_v;
    logic [1:0] valid;
    logic       busy;
    logic [1:0] exp_ready;
  } vec_t;

  ent_t       log_q[$];
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [1:0] hs;
  int         ready_cnt;
  int         start_cnt;
  int         checks;
  int         errors;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: log tx_start, retire accepted bytes, present the queue heads,
  // then note which requesters will handshake on the coming edge.
  task automatic step();
    @(negedge tb_clk);
    if (bus.tx_start) begin
      log_q.push_back('{gid: int'(bus.grant_id), data: int'(bus.tx_data_in)});
      start_cnt++;
    end
    if (hs[0] && q0.size() != 0) void'(q0.pop_front());
    if (hs[1] && q1.size() != 0) void'(q1.pop_front());
    v_valid = {q1.size() != 0, q0.size() != 0};
    v_data  = '0;
    v_last  = '0;
    if (q0.size() != 0) begin v_data[7:0]  = q0[0][7:0]; v_last[0] = q0[0][8]; end
    if (q1.size() != 0) begin v_data[15:8] = q1[0][7:0]; v_last[1] = q1[0][8]; end
    #1;
    hs = bus.req_valid & bus.req_ready;
    if (|bus.req_ready) ready_cnt++;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    hs      = '0;
    v_valid = '0;
    mode    = 0;
    step();
    step();
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (log_q.size() < n && c < budget) begin
      step();
      c++;
    end
    check({name, "_bytes"}, log_q.size(), n);
  endtask

  task automatic check_ent(input string name, input int idx,
                           input int gid, input int data);
    if (idx < log_q.size()) begin
      check({name, "_gid"},  log_q[idx].gid,  gid);
      check({name, "_data"}, log_q[idx].data, data);
    end else begin
      check({name, "_missing"}, log_q.size(), idx + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   r0, s0, n;
    int   lock_exp[3];
    int   lock_gid[3];

    checks = 0; errors = 0; ready_cnt = 0; start_cnt = 0; hs = '0;

    // rr_ptr is NUM_REQ-1 after reset, so requester 0 has priority.
    vecs[0] = '{"none_valid",   1'b0, 2'b00, 1'b0, 2'b00};
    vecs[1] = '{"only_req0",    1'b0, 2'b01, 1'b0, 2'b01};
    vecs[2] = '{"only_req1",    1'b0, 2'b10, 1'b0, 2'b10};
    vecs[3] = '{"both_valid",   1'b0, 2'b11, 1'b0, 2'b01};
    vecs[4] = '{"both_busy",    1'b0, 2'b11, 1'b1, 2'b00};
    vecs[5] = '{"req1_busy",    1'b0, 2'b10, 1'b1, 2'b00};
    vecs[6] = '{"both_in_rst",  1'b1, 2'b11, 1'b0, 2'b00};

`ifdef UART_ARB_LOCK_EN
    lock_exp = '{32'h48, 32'h69, 32'h5A};
    lock_gid = '{0, 0, 1};
`else
    lock_exp = '{32'h48, 32'h5A, 32'h69};
    lock_gid = '{0, 1, 0};
`endif

    // reset state
    step();
    #1;
    check("rst_tx_start", bus.tx_start,   0);
    check("rst_tx_data",  bus.tx_data_in, 8'h00);
    check("rst_grant",    bus.grant_id,   0);
    check("rst_active",   bus.active,     0);
    check("rst_ready",    bus.req_ready,  0);
    rst = 1'b0;

    // combinational ready vectors; valid is withdrawn before the edge
    for (int i = 0; i < 7; i++) begin
      step();
      rst     = vecs[i].rst_v;
      v_valid = vecs[i].valid;
      mode    = vecs[i].busy ? 1 : 2;
      #1;
      check({vecs[i].name, "_ready"},  bus.req_ready, vecs[i].exp_ready);
      check({vecs[i].name, "_active"}, bus.active,    0);
      v_valid = '0;
      mode    = 0;
      rst     = 1'b0;
    end

    // single byte from requester 0
    reset_dut();
    r0 = ready_cnt; s0 = start_cnt;
    q0.push_back({1'b1, 8'h41});
    wait_log(1, 50, "single");
    check_ent("single", 0, 0, 8'h41);
    for (int i = 0; i < 15; i++) step();
    check("single_ready_cycles", ready_cnt - r0, 1);
    check("single_starts",       start_cnt - s0, 1);
    check("single_idle",         bus.active,     0);
    check("single_data_held",    bus.tx_data_in, 8'h41);

    // rotation with both requesters streaming
    reset_dut();
    q0.push_back({1'b1, 8'h41}); q0.push_back({1'b1, 8'h41});
    q1.push_back({1'b1, 8'h42}); q1.push_back({1'b1, 8'h42});
    wait_log(4, 200, "rotation");
    check_ent("rot0", 0, 0, 8'h41);
    check_ent("rot1", 1, 1, 8'h42);
    check_ent("rot2", 2, 0, 8'h41);
    check_ent("rot3", 3, 1, 8'h42);

    // tx_busy held high: nothing may be readied or started
    reset_dut();
    mode = 1;
    r0 = ready_cnt; s0 = start_cnt;
    q0.push_back({1'b1, 8'h11});
    q1.push_back({1'b1, 8'h22});
    for (int i = 0; i < 20; i++) step();
    check("hold_ready_cycles", ready_cnt - r0, 0);
    check("hold_starts",       start_cnt - s0, 0);
    check("hold_active",       bus.active,     0);

    // watchdog: tx_busy never rises
    reset_dut();
    mode = 2;
    q0.push_back({1'b1, 8'h77});
    wait_log(1, 50, "watchdog");
    n = 0;
    while (bus.active && n < 10) begin
      step();
      n++;
    end
    check("watchdog_back_to_idle", bus.active, 0);
    check("watchdog_within_3",     (n >= 1) && (n <= 3), 1);
    check_ent("watchdog", 0, 0, 8'h77);

    // message lock
    reset_dut();
    q0.push_back({1'b0, 8'h48});
    q0.push_back({1'b1, 8'h69});
    q1.push_back({1'b1, 8'h5A});
    wait_log(3, 200, "lock");
    for (int i = 0; i < 3; i++) check_ent($sformatf("lock%0d", i), i,
                                          lock_gid[i], lock_exp[i]);

    // reset while a requester-1 byte is in WAIT_DONE
    reset_dut();
    q1.push_back({1'b1, 8'h42});
    wait_log(1, 50, "midrst");
    step(); step(); step();
    check("midrst_active_before", bus.active,     1);
    check("midrst_grant_before",  bus.grant_id,   1);
    rst = 1'b1;
    #1;
    check("midrst_tx_start", bus.tx_start,   0);
    check("midrst_tx_data",  bus.tx_data_in, 8'h00);
    check("midrst_grant",    bus.grant_id,   0);
    check("midrst_active",   bus.active,     0);
    q0.push_back({1'b1, 8'h41});
    q1.push_back({1'b1, 8'h43});
    r0 = ready_cnt;
    step(); step();
    check("midrst_ready_in_rst", bus.req_ready, 0);
    check("midrst_ready_cycles", ready_cnt - r0, 0);
    log_q.delete();
    rst = 1'b0;
    wait_log(1, 50, "after_rst");
    check_ent("after_rst", 0, 0, 8'h41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single `uart_tx` transmitter between `NUM_REQ` byte-stream requesters, for example the CPU MMIO port and the debug/trace port. It sits directly in front of `uart_tx`. It accepts one byte at a time over a valid/ready handshake and issues a one-cycle `tx_start` with the byte on `tx_data_in`. It then tracks `tx_busy` until the frame completes before granting again.

## Interface
- `NUM_REQ`, 2: number of requesters; legal range 2..8.
- `ID_W`, 1: width of `grant_id`; must satisfy 2^`ID_W` >= `NUM_REQ`.
- `clk` in 1: single clock for the block.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in `NUM_REQ`: bit i high means requester i offers a byte.
- `req_data` in 8*`NUM_REQ`: byte of requester i on bits [8i+7:8i].
- `req_last` in `NUM_REQ`: marks the last byte of a message; used only with `UART_ARB_LOCK_EN`.
- `req_ready` out `NUM_REQ`: one-hot accept strobe.
- `tx_start` out 1: start pulse to `uart_tx`.
- `tx_data_in` out 8: byte to `uart_tx`.
- `tx_busy` in 1: busy flag from `uart_tx`.
- `grant_id` out `ID_W`: index of the last accepted requester.
- `active` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- **IDLE:**
  - The winner is the first i with `req_valid[i]=1`, searching from `rr_ptr+1` modulo `NUM_REQ`.
  - `req_ready[winner]=1` combinationally, only when `tx_busy=0`.
  - A transfer occurs on the clock edge where valid and ready are both high for the same i.
  - On transfer: register `req_data[i]` into `tx_data_in`, set `grant_id=i`, set `rr_ptr=i`, go to START.
- **START:** `tx_start=1` for this cycle only, then go to WAIT_BUSY.
- **WAIT_BUSY:**
  - `tx_busy=1` moves to WAIT_DONE.
  - If `tx_busy` has not risen after 2 cycles in this state, return to IDLE (watchdog; the byte is treated as sent).
- **WAIT_DONE:** `tx_busy=0` moves to IDLE.
- Requester rules:
  - Once `req_valid` is asserted, hold it and `req_data` stable until ready.
  - `req_valid` must not depend on `req_ready`.
  - `req_ready` may depend on `req_valid`.
- `req_ready` is all-zero outside IDLE, while `tx_busy=1`, and while `rst=1`.
- `tx_data_in` holds its value until the next transfer.
- A requester that drops `req_valid` before being accepted loses nothing; it is simply skipped.
- Reset values:
  - `tx_start`=0, `tx_data_in`=0x00, `grant_id`=0, `active`=0, `req_ready`=0.
  - `rr_ptr`=`NUM_REQ`-1, so requester 0 wins first.
  - State=IDLE; lock cleared.
- Reset mid-frame returns immediately to reset values. The in-flight `uart_tx` frame is not the arbiter's concern.

## Timing
- Accept at edge E. `tx_start` is high for exactly one cycle, E to E+1, with `tx_data_in` already valid.
- `uart_tx` asserts `tx_busy` within 1 cycle of `tx_start`. The watchdog covers a missing assertion.
- Next accept is possible on the first edge where the state is IDLE and `tx_busy=0`: at least 2 cycles after `tx_busy` falls.
- Byte period ≈ 10*`CLKS_PER_BIT` + 4 cycles. At 868 this is 8684 cycles, 86.84 µs at 100 MHz.
- Simultaneous valid on all requesters gives strict rotation 0,1,…,`NUM_REQ`-1,0,…

## Configuration
- `UART_ARB_LOCK_EN` defined (message lock):
  - Accepting a byte with `req_last=0` locks the arbiter to that requester.
  - While locked, only that requester is eligible in IDLE. Others are not readied even if the owner's `req_valid=0`; there is no timeout.
  - A byte accepted with `req_last=1` releases the lock. Rotation then resumes from `rr_ptr`.
- `UART_ARB_LOCK_EN` undefined: `req_last` is ignored and arbitration is per byte.

## Test plan
- Use a real `uart_tx` with `CLKS_PER_BIT`=868.
  - Stimulus: requester 0 offers 0x41.
  - Response: `req_ready[0]` high one cycle, one `tx_start` pulse with `tx_data_in`=0x41, serial line decodes 0x41 (start=0, stop=1).
- Rotation:
  - Stimulus: from reset, req0 streams 0x41 and req1 streams 0x42 continuously.
  - Response: transmitted order is 0x41,0x42,0x41,0x42; `grant_id` is 0,1,0,1.
- Stubbed `tx_busy` held at 1 with `req_valid`=11: `req_ready` stays 00 for the whole hold, and no `tx_start` is issued.
- Watchdog: stubbed `tx_busy` held at 0; after the `tx_start` pulse, the FSM returns to IDLE within 3 cycles.
- Message lock:
  - Stimulus: req0 sends 'H'(last=0) then 'i'(last=1); req1 holds 0x5A valid throughout.
  - Response with `UART_ARB_LOCK_EN`: output 'H','i',0x5A.
  - Response without the macro: output 'H',0x5A,'i'.
- Reset mid-operation:
  - Stimulus: `rst` pulsed during WAIT_DONE of a req1 byte.
  - Response: all outputs return to reset values asynchronously, and with both valid the next grant goes to requester 0.
